// File: rtl/dmem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// In-order owner FIFO routes read responses back to their requester.
module dmem_bus_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4,
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1,
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              iram_req,
  input  logic [XLEN-1:0]   iram_addr,
  output logic              iram_ready,
  input  logic              iram_flush,
  output logic              iram_rvalid,
  output logic [XLEN-1:0]   iram_rdata,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  input  logic [XLEN/8-1:0] dram_wstrb,
  output logic              dram_ready,
  output logic              dram_rvalid,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              bus_req,
  output logic              bus_write,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic [OW-1:0]     outstanding,
  output logic              rsp_err
);

  logic [MAX_OUTSTANDING-1:0] r_owner;
  logic [MAX_OUTSTANDING-1:0] r_disc;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [OW-1:0]              r_cnt;
  logic [SW-1:0]              r_starve;
  logic                       r_rsp_err;

  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_ifu_cand;
  logic w_ifu_win;
  logic w_starved;
  logic w_head_own;
  logic w_head_disc;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;

  assign w_empty    = (r_cnt == '0);
  assign w_pop      = bus_rvalid & ~w_empty;
  assign w_full     = (r_cnt == OW'(MAX_OUTSTANDING)) & ~w_pop;
  assign w_ifu_cand = iram_req & ~iram_flush;
  assign w_starved  = (r_starve == SW'(STARVE_LIMIT));
  assign w_ifu_win  = w_ifu_cand & (~dram_req | w_starved);

  // Grant, bus field mux and handshakes; all held low in reset
  always_comb begin
    bus_req    = (w_ifu_cand | dram_req) & ~w_full & rst_b;
    bus_write  = 1'b0;
    bus_addr   = dram_addr;
    bus_wdata  = dram_wdata;
    bus_wstrb  = '0;
    iram_ready = 1'b0;
    dram_ready = 1'b0;
    if (w_ifu_win) begin
      bus_addr   = iram_addr;
      bus_wdata  = '0;
      iram_ready = bus_req & bus_ready;
    end else begin
      bus_write  = dram_write;
      bus_wstrb  = dram_write ? dram_wstrb : '0;
      dram_ready = dram_req & bus_req & bus_ready;
    end
  end

  assign w_push = iram_ready | (dram_ready & ~dram_write);

  assign w_head_own  = r_owner[r_rptr];
  assign w_head_disc = r_disc[r_rptr] | (iram_flush & ~w_head_own);

  // Route the head response to its owner; discarded ones vanish
  always_comb begin
    dram_rvalid = w_pop & w_head_own;
    iram_rvalid = w_pop & ~w_head_own & ~w_head_disc;
  end

  assign iram_rdata  = bus_rdata;
  assign dram_rdata  = bus_rdata;
  assign outstanding = r_cnt;
  assign rsp_err     = r_rsp_err;

  assign w_wptr_nxt = (r_wptr == PW'(MAX_OUTSTANDING - 1)) ?
                      '0 : r_wptr + PW'(1);
  assign w_rptr_nxt = (r_rptr == PW'(MAX_OUTSTANDING - 1)) ?
                      '0 : r_rptr + PW'(1);

  // Owner FIFO storage, pointers, occupancy and flush marking
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_owner <= '0;
      r_disc  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
    end else begin
      if (iram_flush) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          if (!r_owner[i]) r_disc[i] <= 1'b1;
        end
      end
      if (w_push) begin
        r_owner[r_wptr] <= ~iram_ready;
        r_disc[r_wptr]  <= 1'b0;
        r_wptr          <= w_wptr_nxt;
      end
      if (w_pop) r_rptr <= w_rptr_nxt;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + OW'(1);
        2'b01:   r_cnt <= r_cnt - OW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // IFU starvation counter, saturating at the limit
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_starve <= '0;
    end else if (!iram_req || iram_ready) begin
      r_starve <= '0;
    end else if (w_ifu_cand && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Sticky flag for a response with nobody waiting for it
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rsp_err <= 1'b0;
    end else if (bus_rvalid && w_empty) begin
      r_rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter.
// Each task drives one scenario and checks outputs at the negedge.
module tb_dmem_bus_arbiter;

  logic        clk;
  logic        rst_b;
  logic        iram_req;
  logic [31:0] iram_addr;
  logic        iram_ready;
  logic        iram_flush;
  logic        iram_rvalid;
  logic [31:0] iram_rdata;
  logic        dram_req;
  logic        dram_write;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wstrb;
  logic        dram_ready;
  logic        dram_rvalid;
  logic [31:0] dram_rdata;
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic [1:0]  outstanding;
  logic        rsp_err;

  int checks;
  int errors;

  dmem_bus_arbiter #(
    .XLEN(32),
    .MAX_OUTSTANDING(2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .iram_req(iram_req),
    .iram_addr(iram_addr),
    .iram_ready(iram_ready),
    .iram_flush(iram_flush),
    .iram_rvalid(iram_rvalid),
    .iram_rdata(iram_rdata),
    .dram_req(dram_req),
    .dram_write(dram_write),
    .dram_addr(dram_addr),
    .dram_wdata(dram_wdata),
    .dram_wstrb(dram_wstrb),
    .dram_ready(dram_ready),
    .dram_rvalid(dram_rvalid),
    .dram_rdata(dram_rdata),
    .bus_req(bus_req),
    .bus_write(bus_write),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata),
    .outstanding(outstanding),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    iram_req   = 1'b0;
    iram_addr  = '0;
    iram_flush = 1'b0;
    dram_req   = 1'b0;
    dram_write = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    dram_wstrb = '0;
    bus_ready  = 1'b1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_b = 1'b0;
    iram_req = 1'b1;
    dram_req = 1'b1;
    bus_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus_req: got %b want 0", bus_req);
    end
    checks++;
    if ({iram_ready, dram_ready, iram_rvalid, dram_rvalid} !== 4'b0) begin
      errors++;
      $display("FAIL rst_hs: got %b want 0000",
        {iram_ready, dram_ready, iram_rvalid, dram_rvalid});
    end
    checks++;
    if (outstanding !== 2'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_state: got out=%0d err=%b want 0 0",
        outstanding, rsp_err);
    end
    do_reset();
  endtask

  task automatic test_ifu_read();
    do_reset();
    iram_req  = 1'b1;
    iram_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (iram_ready !== 1'b1 || bus_req !== 1'b1) begin
      errors++;
      $display("FAIL ifu_accept: got rdy=%b req=%b want 1 1",
        iram_ready, bus_req);
    end
    checks++;
    if (bus_addr !== 32'h100 || bus_write !== 1'b0 || bus_wstrb !== 4'h0)
    begin
      errors++;
      $display("FAIL ifu_fields: got a=%h w=%b s=%h want 100 0 0",
        bus_addr, bus_write, bus_wstrb);
    end
    @(posedge clk);
    #1;
    iram_req   = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd1) begin
      errors++;
      $display("FAIL ifu_out1: got %0d want 1", outstanding);
    end
    checks++;
    if (iram_rvalid !== 1'b1 || dram_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_rvalid: got i=%b d=%b want 1 0",
        iram_rvalid, dram_rvalid);
    end
    checks++;
    if (iram_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ifu_rdata: got %h want deadbeef", iram_rdata);
    end
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL ifu_out0: got out=%0d err=%b want 0 0",
        outstanding, rsp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_starvation();
    logic exp_i;
    do_reset();
    iram_req  = 1'b1;
    iram_addr = 32'h200;
    dram_req  = 1'b1;
    dram_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      bus_rvalid = (i > 0);
      bus_rdata  = 32'(i);
      exp_i = (i == 4) || (i == 9);
      @(negedge clk);
      checks++;
      if (iram_ready !== exp_i || dram_ready !== !exp_i) begin
        errors++;
        $display("FAIL starve_c%0d: got i=%b d=%b want i=%b d=%b",
          i, iram_ready, dram_ready, exp_i, !exp_i);
      end
      @(posedge clk);
      #1;
    end
    idle();
    bus_rvalid = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_full();
    do_reset();
    dram_req   = 1'b1;
    dram_addr  = 32'h40;
    dram_wstrb = 4'hF;
    @(negedge clk);
    checks++;
    if (dram_ready !== 1'b1 || bus_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL full_ld0: got rdy=%b s=%h want 1 0",
        dram_ready, bus_wstrb);
    end
    @(posedge clk);
    #1;
    dram_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (dram_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ld1: got %b want 1", dram_ready);
    end
    @(posedge clk);
    #1;
    iram_req  = 1'b1;
    dram_addr = 32'h48;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || iram_ready !== 1'b0 || dram_ready !== 1'b0)
    begin
      errors++;
      $display("FAIL full_block: got req=%b i=%b d=%b want 0 0 0",
        bus_req, iram_ready, dram_ready);
    end
    checks++;
    if (outstanding !== 2'd2) begin
      errors++;
      $display("FAIL full_out2: got %0d want 2", outstanding);
    end
    @(posedge clk);
    #1;
    iram_req   = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h55;
    @(negedge clk);
    checks++;
    if (dram_ready !== 1'b1 || dram_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_push: got rdy=%b rv=%b want 1 1",
        dram_ready, dram_rvalid);
    end
    @(posedge clk);
    #1;
    dram_req = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd2) begin
      errors++;
      $display("FAIL full_steady: got %0d want 2", outstanding);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd1) begin
      errors++;
      $display("FAIL full_drain1: got %0d want 1", outstanding);
    end
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL full_drain0: got out=%0d err=%b want 0 0",
        outstanding, rsp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    do_reset();
    iram_req  = 1'b1;
    iram_addr = 32'h200;
    @(posedge clk);
    #1;
    iram_req  = 1'b0;
    dram_req  = 1'b1;
    dram_addr = 32'h80;
    @(posedge clk);
    #1;
    dram_req   = 1'b0;
    iram_req   = 1'b1;
    iram_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (iram_ready !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_block: got rdy=%b req=%b want 0 0",
        iram_ready, bus_req);
    end
    checks++;
    if (outstanding !== 2'd2) begin
      errors++;
      $display("FAIL flush_out: got %0d want 2", outstanding);
    end
    @(posedge clk);
    #1;
    iram_req   = 1'b0;
    iram_flush = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h11;
    @(negedge clk);
    checks++;
    if (iram_rvalid !== 1'b0 || dram_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got i=%b d=%b want 0 0",
        iram_rvalid, dram_rvalid);
    end
    @(posedge clk);
    #1;
    bus_rdata = 32'h22;
    @(negedge clk);
    checks++;
    if (dram_rvalid !== 1'b1 || iram_rvalid !== 1'b0 ||
        dram_rdata !== 32'h22) begin
      errors++;
      $display("FAIL flush_lsu: got d=%b i=%b data=%h want 1 0 22",
        dram_rvalid, iram_rvalid, dram_rdata);
    end
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL flush_end: got out=%0d err=%b want 0 0",
        outstanding, rsp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    do_reset();
    dram_req   = 1'b1;
    dram_write = 1'b1;
    dram_addr  = 32'hC0;
    dram_wdata = 32'hA5A5;
    dram_wstrb = 4'b0011;
    @(negedge clk);
    checks++;
    if (dram_ready !== 1'b1 || bus_write !== 1'b1) begin
      errors++;
      $display("FAIL st_accept: got rdy=%b w=%b want 1 1",
        dram_ready, bus_write);
    end
    checks++;
    if (bus_wstrb !== 4'b0011 || bus_wdata !== 32'hA5A5 ||
        bus_addr !== 32'hC0) begin
      errors++;
      $display("FAIL st_fields: got s=%h d=%h a=%h want 3 a5a5 c0",
        bus_wstrb, bus_wdata, bus_addr);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd0) begin
      errors++;
      $display("FAIL st_nopush: got %0d want 0", outstanding);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rsp_err_and_reset();
    do_reset();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h99;
    @(negedge clk);
    checks++;
    if (iram_rvalid !== 1'b0 || dram_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_route: got i=%b d=%b want 0 0",
        iram_rvalid, dram_rvalid);
    end
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    iram_req   = 1'b1;
    iram_addr  = 32'h400;
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b want 1", rsp_err);
    end
    @(posedge clk);
    #1;
    dram_req   = 1'b1;
    bus_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (outstanding !== 2'd1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got out=%0d err=%b want 1 1",
        outstanding, rsp_err);
    end
    @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || iram_ready !== 1'b0 || dram_ready !== 1'b0)
    begin
      errors++;
      $display("FAIL async_hs: got req=%b i=%b d=%b want 0 0 0",
        bus_req, iram_ready, dram_ready);
    end
    checks++;
    if (outstanding !== 2'd0 || rsp_err !== 1'b0 ||
        iram_rvalid !== 1'b0 || dram_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL async_state: got out=%0d err=%b iv=%b dv=%b want 0",
        outstanding, rsp_err, iram_rvalid, dram_rvalid);
    end
    @(negedge clk);
    idle();
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    bus_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (iram_rvalid !== 1'b0 || dram_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_route: got i=%b d=%b want 0 0",
        iram_rvalid, dram_rvalid);
    end
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_err: got %b want 1", rsp_err);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_b  = 1'b0;
    idle();
    test_reset();
    test_ifu_read();
    test_starvation();
    test_full();
    test_flush();
    test_store();
    test_rsp_err_and_reset();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
